// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, FSM states and widths for alu_pipe
package alu_pkg;
    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_AND  = 4'd1,
        OP_NOR  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLT  = 4'd4,
        OP_SLTU = 4'd5,
        OP_SLL  = 4'd6,
        OP_SRL  = 4'd7,
        OP_SUB  = 4'd8,
        OP_SRA  = 4'd9,
        OP_XOR  = 4'd10,
        OP_MUL  = 4'd11
    } alu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_t;
endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: request/result valid-ready channels of alu_pipe
interface alu_pipe_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) ();
    logic                in_valid;
    logic                in_ready;
    logic [ALU_OP_W-1:0] op;
    logic [WIDTH-1:0]    op1;
    logic [WIDTH-1:0]    op2;
    logic [SHW-1:0]      shamt;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    result;
    logic                zf;
    logic                cf;
    logic                vf;
    logic                err;

    modport master (
        output in_valid, op, op1, op2, shamt, out_ready,
        input  in_ready, out_valid, result, zf, cf, vf, err
    );

    modport slave (
        input  in_valid, op, op1, op2, shamt, out_ready,
        output in_ready, out_valid, result, zf, cf, vf, err
    );
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier, one multiplier bit per cycle, WIDTH cycles per product
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_prod
);
    localparam int SHW = $clog2(WIDTH);

    logic             r_busy;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] w_acc_nxt;

    // the product is taken from the accumulator including the final step's partial product
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_done    = r_busy && (r_cnt == SHW'(WIDTH - 1));
    assign o_prod    = w_acc_nxt;

    // capture operands on start, then one add/shift step per cycle until the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
        end else if (r_busy) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            r_busy   <= !o_done;
        end
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered result/flags; iterative MUL built only with ALU_MUL_EN
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic       clk,
    input logic       rst_n,
    alu_pipe_if.slave bus
);
    logic [WIDTH-1:0] r_result;
    logic             r_out_valid;
    logic             r_zf;
    logic             r_cf;
    logic             r_vf;
    logic             r_err;
    logic             w_accept;
    logic             w_is_mul;
    logic             w_mul_done;
    logic             w_load;
    logic [WIDTH-1:0] w_mul_prod;
    logic [WIDTH-1:0] w_alu_res;
    logic [WIDTH-1:0] w_ld_res;
    logic             w_cf;
    logic             w_vf;
    logic             w_err;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;

    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_sum    = {1'b0, bus.op1} + {1'b0, bus.op2};
    assign w_diff   = {1'b0, bus.op1} + {1'b0, ~bus.op2} + (WIDTH + 1)'(1);

`ifdef ALU_MUL_EN
    alu_state_t r_state;
    alu_state_t w_state_nxt;

    assign w_is_mul     = bus.op == OP_MUL;
    assign bus.in_ready = (r_state == IDLE) && (!r_out_valid || bus.out_ready);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // enter MUL on an accepted multiply, leave when the engine finishes
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == IDLE && w_accept && w_is_mul) w_state_nxt = MUL;
        else if (r_state == MUL && w_mul_done)       w_state_nxt = IDLE;
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_accept && w_is_mul),
        .i_a     (bus.op1),
        .i_b     (bus.op2),
        .o_done  (w_mul_done),
        .o_prod  (w_mul_prod)
    );
`else
    assign w_is_mul     = 1'b0;
    assign w_mul_done   = 1'b0;
    assign w_mul_prod   = '0;
    assign bus.in_ready = !r_out_valid || bus.out_ready;
`endif

    // single-cycle result mux and ADD/SUB flags; anything not listed (incl. MUL when absent) is illegal
    always_comb begin
        w_alu_res = '0;
        w_cf      = 1'b0;
        w_vf      = 1'b0;
        w_err     = 1'b0;
        case (bus.op)
            OP_ADD: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_cf      = w_sum[WIDTH];
                w_vf      = (bus.op1[WIDTH-1] == bus.op2[WIDTH-1]) && (w_sum[WIDTH-1] != bus.op1[WIDTH-1]);
            end
            OP_AND:  w_alu_res = bus.op1 & bus.op2;
            OP_NOR:  w_alu_res = ~(bus.op1 | bus.op2);
            OP_OR:   w_alu_res = bus.op1 | bus.op2;
            OP_SLT:  w_alu_res = WIDTH'($signed(bus.op1) < $signed(bus.op2));
            OP_SLTU: w_alu_res = WIDTH'(bus.op1 < bus.op2);
            OP_SLL:  w_alu_res = bus.op2 << bus.shamt;
            OP_SRL:  w_alu_res = bus.op2 >> bus.shamt;
            OP_SUB: begin
                w_alu_res = w_diff[WIDTH-1:0];
                w_cf      = !w_diff[WIDTH];
                w_vf      = (bus.op1[WIDTH-1] != bus.op2[WIDTH-1]) && (w_diff[WIDTH-1] != bus.op1[WIDTH-1]);
            end
            OP_SRA:  w_alu_res = $unsigned($signed(bus.op2) >>> bus.shamt);
            OP_XOR:  w_alu_res = bus.op1 ^ bus.op2;
            default: w_err = 1'b1;
        endcase
    end

    assign w_load   = (w_accept && !w_is_mul) || w_mul_done;
    assign w_ld_res = w_mul_done ? w_mul_prod : w_alu_res;

    // output register: load on a new result, clear valid on consumption, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_zf        <= 1'b0;
            r_cf        <= 1'b0;
            r_vf        <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_load) begin
            r_result    <= w_ld_res;
            r_out_valid <= 1'b1;
            r_zf        <= w_ld_res == '0;
            r_cf        <= !w_mul_done && w_cf;
            r_vf        <= !w_mul_done && w_vf;
            r_err       <= !w_mul_done && w_err;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.result    = r_result;
    assign bus.out_valid = r_out_valid;
    assign bus.zf        = r_zf;
    assign bus.cf        = r_cf;
    assign bus.vf        = r_vf;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed checks of alu_pipe (reset, flags, shifts, compares, backpressure, MUL/illegal, random stream)
module tb_alu_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    alu_pipe_if #(.WIDTH(32)) bus ();

    alu_pipe #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return {28'd0, bus.zf, bus.cf, bus.vf, bus.err};
    endfunction

    // present one request at a negedge; it is taken at the next posedge when in_ready is high
    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
        bus.op       = o;
        bus.op1      = a;
        bus.op2      = b;
        bus.shamt    = s;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
        case (o)
            4'd0:    return a + b;
            4'd1:    return a & b;
            4'd2:    return ~(a | b);
            4'd3:    return a | b;
            4'd4:    return {31'd0, $signed(a) < $signed(b)};
            4'd5:    return {31'd0, a < b};
            4'd6:    return b << s;
            4'd7:    return b >> s;
            4'd8:    return a - b;
            4'd9:    return $unsigned($signed(b) >>> s);
            4'd10:   return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        logic [31:0] exp_res;
        logic        acc_prev;
        logic [31:0] q[$];
        int          sent;
        int          got;
        int          bad;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.op        = '0;
        bus.op1       = '0;
        bus.op2       = '0;
        bus.shamt     = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_flags", flags(), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(4'd0, 32'h7FFF_FFFF, 32'h1, 5'd0);
        chk("add_ovf_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("add_ovf_res", bus.result, 32'h8000_0000);
        chk("add_ovf_flags", flags(), 32'b0010);
        do_op(4'd0, 32'hFFFF_FFFF, 32'h1, 5'd0);
        chk("add_carry_res", bus.result, 32'h0);
        chk("add_carry_flags", flags(), 32'b1100);
        do_op(4'd8, 32'd1, 32'd2, 5'd0);
        chk("sub_borrow_res", bus.result, 32'hFFFF_FFFF);
        chk("sub_borrow_flags", flags(), 32'b0100);
        do_op(4'd8, 32'h8000_0000, 32'd1, 5'd0);
        chk("sub_ovf_res", bus.result, 32'h7FFF_FFFF);
        chk("sub_ovf_flags", flags(), 32'b0010);
        do_op(4'd9, 32'd0, 32'h8000_0000, 5'd4);
        chk("sra", bus.result, 32'hF800_0000);
        do_op(4'd7, 32'd0, 32'h8000_0000, 5'd4);
        chk("srl", bus.result, 32'h0800_0000);
        do_op(4'd6, 32'd0, 32'h1, 5'd31);
        chk("sll", bus.result, 32'h8000_0000);
        do_op(4'd4, 32'hFFFF_FFFF, 32'd1, 5'd0);
        chk("slt", bus.result, 32'd1);
        do_op(4'd5, 32'hFFFF_FFFF, 32'd1, 5'd0);
        chk("sltu_res", bus.result, 32'd0);
        chk("sltu_flags", flags(), 32'b1000);
        do_op(4'd1, 32'hF0F0_1234, 32'h0FF0_00FF, 5'd0);
        chk("and", bus.result, 32'h00F0_0034);
        do_op(4'd3, 32'hF0F0_1234, 32'h0FF0_00FF, 5'd0);
        chk("or", bus.result, 32'hFFF0_12FF);
        do_op(4'd2, 32'hF0F0_1234, 32'h0FF0_00FF, 5'd0);
        chk("nor", bus.result, 32'h000F_ED00);
        do_op(4'd10, 32'hF0F0_1234, 32'h0FF0_00FF, 5'd0);
        chk("xor", bus.result, 32'hFF00_12CB);
        do_op(4'd13, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);
        chk("ill13_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("ill13_res", bus.result, 32'd0);
        chk("ill13_flags", flags(), 32'b1001);
        @(negedge clk);
        chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);

        bus.out_ready = 1'b0;
        do_op(4'd0, 32'd5, 32'd6, 5'd0);
        chk("bp_first", bus.result, 32'd11);
        bus.op1      = 32'd1;
        bus.op2      = 32'd1;
        bus.in_valid = 1'b1;
        #1;
        chk("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.result !== 32'd11 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
        end
        chk("bp_hold", bad, 0);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp_swap_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp_swap_res", bus.result, 32'd2);
        @(negedge clk);
        chk("bp_empty", {31'd0, bus.out_valid}, 32'd0);

`ifdef ALU_MUL_EN
        bus.out_ready = 1'b0;
        do_op(4'd11, 32'd12345, 32'd678, 5'd0);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("mul_busy", bad, 0);
        chk("mul_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("mul_res", bus.result, 32'h007F_B6F6);
        chk("mul_flags", flags(), 32'b0000);
        bus.op       = 4'd0;
        bus.op1      = 32'd3;
        bus.op2      = 32'd4;
        bus.in_valid = 1'b1;
        bad = 0;
        repeat (5) begin
            #1;
            if (bus.in_ready !== 1'b0 || bus.result !== 32'h007F_B6F6 || bus.out_valid !== 1'b1) bad++;
            @(negedge clk);
        end
        chk("mul_hold", bad, 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("mul_next", bus.result, 32'd7);
        do_op(4'd11, 32'hFFFF_FFFD, 32'd5, 5'd0);
        repeat (32) @(negedge clk);
        chk("mul_signed", bus.result, 32'hFFFF_FFF1);
        do_op(4'd11, 32'd0, 32'd99, 5'd0);
        repeat (32) @(negedge clk);
        chk("mul_zero_flags", flags(), 32'b1000);
        do_op(4'd11, 32'd7, 32'd9, 5'd0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmul_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rstmul_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rstmul_res", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) bad++;
        end
        chk("rstmul_stale", bad, 0);
`else
        do_op(4'd11, 32'd12345, 32'd678, 5'd0);
        chk("ill11_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("ill11_res", bus.result, 32'd0);
        chk("ill11_flags", flags(), 32'b1001);
        @(negedge clk);
`endif

        bus.out_ready = 1'b0;
        do_op(4'd0, 32'd5, 32'd6, 5'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_mid_res", bus.result, 32'd0);
        chk("rst_mid_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);

        acc_prev = 1'b0;
        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
            @(negedge clk);
            if (acc_prev) bus.in_valid = 1'b0;
            if (sent < 8 && !bus.in_valid) begin
                bus.op       = 4'($urandom_range(0, 10));
                bus.op1      = $urandom;
                bus.op2      = $urandom;
                bus.shamt    = 5'($urandom_range(0, 31));
                bus.in_valid = 1'b1;
            end
            bus.out_ready = (cyc % 2) == 0;
            #1;
            acc_prev = bus.in_valid && bus.in_ready;
            if (bus.out_valid && bus.out_ready) begin
                exp_res = q.size() > 0 ? q.pop_front() : 32'hxxxx_xxxx;
                chk("rnd_res", bus.result, exp_res);
                got++;
            end
            if (acc_prev) begin
                q.push_back(ref_alu(bus.op, bus.op1, bus.op2, bus.shamt));
                sent++;
            end
        end
        chk("rnd_count", got, 32'd8);
        chk("rnd_left", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
